cache_arbiter: RTL

Parametrised N-port arbiter placed between the processor cores and the shared cache RAM. It replaces the fixed two-port, externally selected cache multiplexer. Selection is made internally by fair round-robin arbitration under a request/grant handshake. Cache-side signals are registered, and read data is routed back to the issuing port with a tagged valid after a fixed cache latency.

---
 rtl/cache_arb_pkg.sv | 25 ++
 rtl/cache_arbiter_rr.sv | 40 ++++
 rtl/cache_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and limits for the cache arbiter: index sizing helper,
// read-return tag record and parameter bounds.
package cache_arb_pkg;

    localparam int unsigned MAX_PORTS  = 8;
    localparam int unsigned MAX_RD_LAT = 4;

    // Index width for a given count, never narrower than one bit
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

    localparam int unsigned TAG_IDX_W = clog2(MAX_PORTS);

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } rd_tag_t;

endpackage

// File: rtl/cache_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr wins,
// searching upward and wrapping modulo N_PORTS.
module rr_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned IDX_W   = clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [N_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_any
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] port;

    always_comb begin
        gnt     = '0;
        win_idx = '0;
        win_any = 1'b0;
        sum     = '0;
        port    = '0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            // ptr < N_PORTS and i < N_PORTS, so one subtraction wraps
            sum = (IDX_W+1)'(ptr) + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N_PORTS)) begin
                sum = sum - (IDX_W+1)'(N_PORTS);
            end
            port = sum[IDX_W-1:0];
            if (!win_any && req[port]) begin
                win_any   = 1'b1;
                gnt[port] = 1'b1;
                win_idx   = port;
            end
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// N-port round-robin front end for the shared cache RAM: registered cache
// issue stage and tagged read-data return after a fixed cache latency.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          req,
    input  logic [N_PORTS-1:0]          we,
    input  logic [N_PORTS*ADDR_W-1:0]   addr,
    input  logic [N_PORTS*DATA_W-1:0]   wdata,
    output logic [N_PORTS-1:0]          gnt,
    output logic [N_PORTS-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic [ADDR_W-1:0]           cache_Addr,
    output logic [DATA_W-1:0]           cache_DataIn,
    output logic                        cache_WE,
    output logic                        cache_En,
    input  logic [DATA_W-1:0]           cache_DataOut
);

    localparam int unsigned IDX_W = clog2(N_PORTS);

    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_next;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_we;
    rd_tag_t            issue_tag_q;
    rd_tag_t            tag_pipe_q [RD_LAT];
    rd_tag_t            out_tag;
    logic [N_PORTS-1:0] rvalid_next;

    rr_arbiter #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .win_idx (win_idx),
        .win_any (win_any)
    );

    // Winner's request fields, selected by the one-hot grant
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            if (gnt[i]) begin
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
                sel_we    = we[i];
            end
        end
    end

    assign ptr_next = (win_idx == IDX_W'(N_PORTS - 1)) ? '0 : win_idx + IDX_W'(1);

    // Issue stage; address/data hold when idle, strobes drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q             <= '0;
            cache_En          <= 1'b0;
            cache_WE          <= 1'b0;
            cache_Addr        <= '0;
            cache_DataIn      <= '0;
            issue_tag_q.valid <= 1'b0;
            issue_tag_q.idx   <= '0;
        end else begin
            cache_En          <= win_any;
            cache_WE          <= win_any & sel_we;
            issue_tag_q.valid <= win_any & ~sel_we;
            issue_tag_q.idx   <= TAG_IDX_W'(win_idx);
            if (win_any) begin
                ptr_q        <= ptr_next;
                cache_Addr   <= sel_addr;
                cache_DataIn <= sel_wdata;
            end
        end
    end

    // Tag delay line aligned so the oldest stage coincides with cache_DataOut
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                tag_pipe_q[i].valid <= 1'b0;
                tag_pipe_q[i].idx   <= '0;
            end
        end else begin
            tag_pipe_q[0] <= issue_tag_q;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                tag_pipe_q[i] <= tag_pipe_q[i-1];
            end
        end
    end

    assign out_tag = tag_pipe_q[RD_LAT-1];

    always_comb begin
        rvalid_next = '0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            rvalid_next[i] = out_tag.valid && (out_tag.idx == TAG_IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= rvalid_next;
            if (out_tag.valid) begin
                rdata <= cache_DataOut;
            end
        end
    end

endmodule
